lms_weight_updater: RTL
=======================

Name: lms_weight_updater

Overview:
- Sequential LMS update engine: the writer side of the per-tap coefficient registers.
- On each start pulse it sweeps all taps. For every tap it reads the current weight and the delay-line sample, then writes back w + mu*e*x, saturated.
- Sits between the error computation and the coefficient bank; drives the bank's read and write enables.

Parameters:
- N_TAPS, 8, number of filter taps / coefficients swept per update
- DATA_W, 16, width of weights, samples and error; signed Q1.15
- ADDR_W, $clog2(N_TAPS), tap index width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to run an update sweep; honoured only when idle
- error  in  DATA_W  signed Q1.15 error e; sampled on the accepted start
- mu_shift  in  4  step size mu = 2^-mu_shift (0..15); sampled on the accepted start
- x_addr  out  ADDR_W  delay-line tap index
- x_data  in  DATA_W  signed sample x[x_addr]; combinational, same cycle
- coef_rd_en  out  1  coefficient read enable
- coef_rd_addr  out  ADDR_W  coefficient read index
- coef_rd_data  in  DATA_W  weight at coef_rd_addr; valid in the same cycle while coef_rd_en=1
- coef_wr_en  out  1  coefficient write enable, one cycle per tap
- coef_wr_addr  out  ADDR_W  coefficient write index
- coef_wr_data  out  DATA_W  updated weight
- busy  out  1  high while a sweep is in progress
- done  out  1  one-cycle pulse when the sweep completes

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, idx=0.
  - All outputs 0 from the first edge with reset=1.
  - Internal e_reg and w_new_reg cleared.
- States:
  - IDLE: busy=0. If start=1, latch e_reg = error >>> mu_shift (arithmetic shift), set idx=0, go to READ.
  - READ: coef_rd_en=1; coef_rd_addr = x_addr = idx. Register w_new_reg = sat(w + delta). Go to WRITE.
  - WRITE: coef_wr_en=1, coef_wr_addr=idx, coef_wr_data=w_new_reg. If idx==N_TAPS-1 go to DONE; otherwise idx++ and go to READ.
  - DONE: done=1, busy=1 for this one cycle; then go to IDLE.
- busy=1 in READ, WRITE and DONE. coef_rd_en and coef_wr_en are never high in the same cycle.
- Outputs are registered/decoded from state. Address outputs read 0 when not in READ or WRITE.
- Timing: start sampled at edge t gives READ tap0 in cycle t+1, WRITE tap0 in t+2, WRITE tap N-1 in t+2N, done in t+2N+1. A new start is accepted at t+2N+2 at the earliest.
- Arithmetic:
  - prod = e_reg * x_data, 2*DATA_W signed.
  - delta = prod >>> 15, truncation toward -inf, kept at 17 bits.
  - sum = sext(w) + delta, 18 bits.
  - Saturate to [0x8000, 0x7FFF].
  - mu_shift=0 means mu=1.
- Boundaries:
  - start while busy is ignored; error and mu_shift are not re-sampled.
  - error=0 still performs the full sweep and rewrites unchanged weights.
  - Reset mid-sweep: abort, no further writes; taps already written keep their new values. The next start begins again at tap 0.
  - Changes to error or mu_shift after start do not affect the current sweep.

Decomposition:
- Shared package lms_pkg:
  - DATA_W
  - FRAC_BITS=15
  - W_MAX=16'sh7FFF, W_MIN=16'sh8000
  - updater state enum {IDLE, READ, WRITE, DONE}
- One sub-module, lms_tap_update: combinational multiply, shift and saturate. Inputs w, x, e_reg; output w_new. The FSM registers its result.

Test Plan:
- Reset: assert reset 2 cycles mid-idle -> busy=done=coef_rd_en=coef_wr_en=0, all addresses and data 0.
- Nominal sweep, N=8:
  - Stimulus: all w=0x0000, all x=0x4000, error=0x4000, mu_shift=1.
  - Required: 8 writes of 0x1000 to addresses 0..7, each WRITE one cycle after its READ; done exactly at t+17; busy low at t+18.
- Positive saturation: w=0x7F00, x=0x7FFF, error=0x7FFF, mu_shift=0 -> delta=0x7FFE, coef_wr_data=0x7FFF.
- Negative saturation and rounding:
  - w=0x8100, x=0x7FFF, error=0x8000, mu_shift=0 -> coef_wr_data=0x8000.
  - Separately, w=0, x=0x0001, error=0xFFFF -> coef_wr_data=0xFFFF (floor).
- Start while busy: pulse start again in cycle t+5 with a different error -> ignored; writes match the first error; exactly 8 writes and one done pulse.
- Reset mid-sweep: assert reset in the cycle after WRITE of tap 2 -> no further coef_wr_en. A subsequent start sweeps taps 0..7 again, with done at start+17.

Source files
------------

// File: rtl/lms_pkg.sv
// Shared types and constants for the LMS coefficient update engine.
package lms_pkg;

  localparam int DATA_W    = 16;
  localparam int FRAC_BITS = 15;

  localparam logic signed [DATA_W-1:0] W_MAX = 16'sh7FFF;
  localparam logic signed [DATA_W-1:0] W_MIN = 16'sh8000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } upd_state_e;

endpackage

// File: rtl/lms_tap_update.sv
// Combinational per-tap update: w + ((e*x) >>> 15), saturated to Q1.15.
module lms_tap_update
  import lms_pkg::*;
(
  input  logic signed [DATA_W-1:0] w_i,
  input  logic signed [DATA_W-1:0] x_i,
  input  logic signed [DATA_W-1:0] e_i,
  output logic signed [DATA_W-1:0] w_new_o
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [DATA_W:0]     delta;
  logic signed [DATA_W+1:0]   sum;

  always_comb begin
    prod  = e_i * x_i;
    // Arithmetic shift floors toward -inf; the result always fits in 17 bits.
    delta = (DATA_W+1)'(prod >>> FRAC_BITS);
    sum   = {{2{w_i[DATA_W-1]}}, w_i} + {delta[DATA_W], delta};
    if (sum[DATA_W+1:DATA_W-1] == 3'b000 || sum[DATA_W+1:DATA_W-1] == 3'b111) begin
      w_new_o = sum[DATA_W-1:0];
    end else if (sum[DATA_W+1]) begin
      w_new_o = W_MIN;
    end else begin
      w_new_o = W_MAX;
    end
  end

endmodule

// File: rtl/lms_weight_updater.sv
// LMS sweep engine: per tap, read weight and sample, then write back the saturated update.
module lms_weight_updater
  import lms_pkg::*;
#(
  parameter int N_TAPS = 8,
  parameter int DATA_W = 16,
  parameter int ADDR_W = $clog2(N_TAPS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] error,
  input  logic [3:0]               mu_shift,
  output logic [ADDR_W-1:0]        x_addr,
  input  logic signed [DATA_W-1:0] x_data,
  output logic                     coef_rd_en,
  output logic [ADDR_W-1:0]        coef_rd_addr,
  input  logic signed [DATA_W-1:0] coef_rd_data,
  output logic                     coef_wr_en,
  output logic [ADDR_W-1:0]        coef_wr_addr,
  output logic [DATA_W-1:0]        coef_wr_data,
  output logic                     busy,
  output logic                     done
);

  upd_state_e                state_q;
  logic [ADDR_W-1:0]         idx_q;
  logic signed [DATA_W-1:0]  e_q;
  logic signed [DATA_W-1:0]  w_new_q;
  logic signed [DATA_W-1:0]  w_new_d;

  lms_tap_update u_tap (
    .w_i     (coef_rd_data),
    .x_i     (x_data),
    .e_i     (e_q),
    .w_new_o (w_new_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      e_q     <= '0;
      w_new_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            // mu is applied once to the error so the per-tap path is a single multiply.
            e_q     <= error >>> mu_shift;
            idx_q   <= '0;
            state_q <= READ;
          end
        end
        READ: begin
          w_new_q <= w_new_d;
          state_q <= WRITE;
        end
        WRITE: begin
          if (idx_q == ADDR_W'(N_TAPS - 1)) begin
            state_q <= DONE;
          end else begin
            idx_q   <= idx_q + ADDR_W'(1);
            state_q <= READ;
          end
        end
        DONE: begin
          idx_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // All outputs decode directly from registered state, so they are glitch-free and zero when idle.
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign coef_rd_en   = (state_q == READ);
  assign coef_wr_en   = (state_q == WRITE);
  assign coef_rd_addr = (state_q == READ)  ? idx_q : '0;
  assign x_addr       = (state_q == READ)  ? idx_q : '0;
  assign coef_wr_addr = (state_q == WRITE) ? idx_q : '0;
  assign coef_wr_data = (state_q == WRITE) ? w_new_q : '0;

endmodule
